// File: rtl/cdc_hs_pkg.sv
// Shared types and helpers for the four-phase req/ack handshake pair.
package cdc_hs_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      REQ_HI = 2'd2,
      REQ_LO = 2'd3
   } hs_tx_state_t;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Asynchronously cleared flop chain bringing a single foreign-domain bit into clk.
module sync_chain #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) ff <= '0;
      else     ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-domain side of a four-phase req/ack crossing: latches a word, holds it on
// xdata, raises xreq after a setup delay and completes on the synchronised xack.
module cdc_handshake_tx
   import cdc_hs_pkg::*;
#(
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned SETUP_CYCLES = 1,
   parameter int unsigned TIMEOUT      = 0
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              send_valid,
   input  logic [DATA_W-1:0] send_data,
   output logic              send_ready,
   output logic              done,
   output logic              timeout_err,
   output logic              xreq,
   output logic [DATA_W-1:0] xdata,
   input  logic              xack
);

   localparam int unsigned SET_W = cnt_width(SETUP_CYCLES - 1);
   localparam int unsigned TO_W  = cnt_width(TIMEOUT);
   localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETUP_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit               TO_EN    = (TIMEOUT > 0);

   hs_tx_state_t      state_q, state_d;
   logic [SET_W-1:0]  set_cnt_q, set_cnt_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              xreq_q, xreq_d;
   logic              done_q, done_d;
   logic              terr_q, terr_d;
   logic              abort_q, abort_d;
   logic              ack_s;

   sync_chain #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk (clk),
      .clr (clr),
      .d   (xack),
      .q   (ack_s)
   );

   // State and datapath registers
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q   <= IDLE;
         set_cnt_q <= '0;
         to_cnt_q  <= '0;
         data_q    <= '0;
         xreq_q    <= 1'b0;
         done_q    <= 1'b0;
         terr_q    <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         set_cnt_q <= set_cnt_d;
         to_cnt_q  <= to_cnt_d;
         data_q    <= data_d;
         xreq_q    <= xreq_d;
         done_q    <= done_d;
         terr_q    <= terr_d;
         abort_q   <= abort_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      set_cnt_d = set_cnt_q;
      to_cnt_d  = to_cnt_q;
      data_d    = data_q;
      xreq_d    = xreq_q;
      done_d    = 1'b0;
      terr_d    = 1'b0;
      abort_d   = abort_q;

      case (state_q)
         IDLE: begin
            xreq_d = 1'b0;
            if (send_valid && !ack_s) begin
               data_d    = send_data;
               set_cnt_d = SET_LOAD;
               state_d   = SETUP;
            end
         end

         // xack is deliberately not looked at here; an early ack cannot shortcut setup
         SETUP: begin
            xreq_d = 1'b0;
            if (set_cnt_q == '0) begin
               xreq_d   = 1'b1;
               to_cnt_d = '0;
               state_d  = REQ_HI;
            end else begin
               set_cnt_d = set_cnt_q - SET_W'(1);
            end
         end

         REQ_HI: begin
            xreq_d = 1'b1;
            if (ack_s) begin
               xreq_d  = 1'b0;
               state_d = REQ_LO;
            end else if (TO_EN) begin
               if (to_cnt_q == TO_LAST) begin
                  xreq_d  = 1'b0;
                  terr_d  = 1'b1;
                  abort_d = 1'b1;
                  state_d = REQ_LO;
               end else begin
                  to_cnt_d = to_cnt_q + TO_W'(1);
               end
            end
         end

         REQ_LO: begin
            xreq_d = 1'b0;
            if (!ack_s) begin
               done_d  = !abort_q;
               abort_d = 1'b0;
               state_d = IDLE;
            end
         end

         default: begin
            xreq_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign send_ready  = (state_q == IDLE) && !ack_s;
   assign done        = done_q;
   assign timeout_err = terr_q;
   assign xreq        = xreq_q;
   assign xdata       = data_q;

endmodule
